// File: rtl/riscv_pkg.sv
// Shared core types: bus widths, requester IDs and the memory request record.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int MEM_BE_W = 4;

    typedef enum logic {
        REQ_IFETCH = 1'b0,
        REQ_LSU    = 1'b1
    } requester_id_e;

    typedef struct packed {
        logic                we;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
        logic [MEM_BE_W-1:0] be;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of both requester ports and the shared memory port.
// slave = arbiter view, master = core/memory-model view.
interface mem_port_arbiter_if #(
    parameter int XLEN = riscv_pkg::XLEN
);
    import riscv_pkg::*;

    logic                m0_req_i, m0_we_i, m0_gnt_o, m0_rvalid_o;
    logic [XLEN-1:0]     m0_addr_i, m0_wdata_i, m0_rdata_o;
    logic [MEM_BE_W-1:0] m0_be_i;
    logic                m1_req_i, m1_we_i, m1_gnt_o, m1_rvalid_o;
    logic [XLEN-1:0]     m1_addr_i, m1_wdata_i, m1_rdata_o;
    logic [MEM_BE_W-1:0] m1_be_i;
    logic                mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, err_o;
    logic [XLEN-1:0]     mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [MEM_BE_W-1:0] mem_be_o;

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_be_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, err_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_wdata_i, m0_be_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_be_i,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, err_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/arb_id_fifo.sv
// In-order FIFO of requester IDs for outstanding memory accesses.
// A push is accepted while full when a pop happens in the same cycle.
module arb_id_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  requester_id_e push_id_i,
    input  logic          pop_i,
    output requester_id_e head_id_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    requester_id_e    slots_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign do_pop    = pop_i && !empty_o;
    assign do_push   = push_i && (!full_o || do_pop);
    assign head_id_o = slots_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: slot storage has no reset; count_q gates every read, so stale slots are never observed.
    always_ff @(posedge clk_i) begin
        if (do_push) slots_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch (M0) and LSU (M1).
// Define ARB_PERF_CNT_EN to add grant/stall performance counters.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int XLEN            = riscv_pkg::XLEN,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0] m0_gnt_cnt_o,
    output logic [31:0] m1_gnt_cnt_o,
    output logic [31:0] stall_cnt_o
`endif
);

    requester_id_e last_grant_q, last_grant_d, lock_id_q, lock_id_d, sel, head_id;
    logic          lock_q, lock_d, sel_req, can_issue, accept, resp_ok;
    logic          fifo_full, fifo_empty;

    // A stalled request (mem_gnt_i low) keeps its selection until accepted.
    always_comb begin
        sel = REQ_IFETCH;
        if (lock_q)                                sel = lock_id_q;
        else if (bus.m0_req_i && bus.m1_req_i)     sel = (last_grant_q == REQ_IFETCH) ? REQ_LSU : REQ_IFETCH;
        else if (bus.m1_req_i)                     sel = REQ_LSU;
    end

    always_comb begin
        sel_req         = bus.m0_req_i;
        bus.mem_we_o    = bus.m0_we_i;
        bus.mem_addr_o  = bus.m0_addr_i;
        bus.mem_wdata_o = bus.m0_wdata_i;
        bus.mem_be_o    = bus.m0_be_i;
        if (sel == REQ_LSU) begin
            sel_req         = bus.m1_req_i;
            bus.mem_we_o    = bus.m1_we_i;
            bus.mem_addr_o  = bus.m1_addr_i;
            bus.mem_wdata_o = bus.m1_wdata_i;
            bus.mem_be_o    = bus.m1_be_i;
        end
    end

    assign can_issue     = !fifo_full || bus.mem_rvalid_i;
    assign bus.mem_req_o = sel_req && can_issue;
    assign accept        = bus.mem_req_o && bus.mem_gnt_i;
    assign bus.m0_gnt_o  = accept && (sel == REQ_IFETCH);
    assign bus.m1_gnt_o  = accept && (sel == REQ_LSU);

    assign resp_ok         = bus.mem_rvalid_i && !fifo_empty;
    assign bus.err_o       = bus.mem_rvalid_i && fifo_empty;
    assign bus.m0_rvalid_o = resp_ok && (head_id == REQ_IFETCH);
    assign bus.m1_rvalid_o = resp_ok && (head_id == REQ_LSU);
    assign bus.m0_rdata_o  = bus.m0_rvalid_o ? bus.mem_rdata_i : {XLEN{1'b0}};
    assign bus.m1_rdata_o  = bus.m1_rvalid_o ? bus.mem_rdata_i : {XLEN{1'b0}};

    always_comb begin
        last_grant_d = last_grant_q;
        lock_d       = bus.mem_req_o && !bus.mem_gnt_i;
        lock_id_d    = sel;
        if (accept) last_grant_d = sel;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= REQ_LSU;
            lock_q       <= 1'b0;
            lock_id_q    <= REQ_IFETCH;
        end else begin
            last_grant_q <= last_grant_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
        end
    end

    arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (accept),
        .push_id_i (sel),
        .pop_i     (bus.mem_rvalid_i),
        .head_id_o (head_id),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

`ifdef ARB_PERF_CNT_EN
    logic [31:0] m0_cnt_q, m0_cnt_d, m1_cnt_q, m1_cnt_d, stall_cnt_q, stall_cnt_d;

    always_comb begin
        m0_cnt_d    = m0_cnt_q + 32'(bus.m0_gnt_o);
        m1_cnt_d    = m1_cnt_q + 32'(bus.m1_gnt_o);
        stall_cnt_d = stall_cnt_q + 32'((bus.m0_req_i || bus.m1_req_i) && !accept);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m0_cnt_q    <= '0;
            m1_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            m0_cnt_q    <= m0_cnt_d;
            m1_cnt_q    <= m1_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign m0_gnt_cnt_o = m0_cnt_q;
    assign m1_gnt_cnt_o = m1_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; ARB_PERF_CNT_EN also exercises the counters.
module tb_mem_port_arbiter;

    logic clk_i;
    logic rst_i;
    int   tests;
    int   fails;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] m0_gnt_cnt, m1_gnt_cnt, stall_cnt;
`endif

    mem_port_arbiter #(.XLEN(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
`ifdef ARB_PERF_CNT_EN
        ,
        .m0_gnt_cnt_o (m0_gnt_cnt),
        .m1_gnt_cnt_o (m1_gnt_cnt),
        .stall_cnt_o  (stall_cnt)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.m0_req_i = 0; bus.m0_we_i = 0; bus.m0_addr_i = '0; bus.m0_wdata_i = '0; bus.m0_be_i = '0;
        bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_addr_i = '0; bus.m1_wdata_i = '0; bus.m1_be_i = '0;
        bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    endtask

    // Inputs change 1 time unit after a rising edge; checks land mid-cycle.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst_i = 1'b1;
        idle();
        #2;
        check("rst_m0_gnt",    {31'b0, bus.m0_gnt_o},    32'd0);
        check("rst_m1_gnt",    {31'b0, bus.m1_gnt_o},    32'd0);
        check("rst_m0_rvalid", {31'b0, bus.m0_rvalid_o}, 32'd0);
        check("rst_m1_rvalid", {31'b0, bus.m1_rvalid_o}, 32'd0);
        check("rst_mem_req",   {31'b0, bus.mem_req_o},   32'd0);
        check("rst_err",       {31'b0, bus.err_o},       32'd0);
        tick();
        rst_i = 1'b0;

        // Lone M0 read, answered the next cycle.
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h100; bus.m0_be_i = 4'hF; bus.mem_gnt_i = 1;
        settle();
        check("t1_m0_gnt",    {31'b0, bus.m0_gnt_o}, 32'd1);
        check("t1_m1_gnt",    {31'b0, bus.m1_gnt_o}, 32'd0);
        check("t1_mem_req",   {31'b0, bus.mem_req_o}, 32'd1);
        check("t1_mem_addr",  bus.mem_addr_o, 32'h100);
        check("t1_mem_be",    {28'b0, bus.mem_be_o}, 32'hF);
        tick();
        idle();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hDEADBEEF;
        settle();
        check("t1_m0_rvalid", {31'b0, bus.m0_rvalid_o}, 32'd1);
        check("t1_m0_rdata",  bus.m0_rdata_o, 32'hDEADBEEF);
        check("t1_m1_rvalid", {31'b0, bus.m1_rvalid_o}, 32'd0);
        check("t1_m1_rdata",  bus.m1_rdata_o, 32'h0);
        check("t1_err",       {31'b0, bus.err_o}, 32'd0);
        tick();
        idle();

        // Reset so last_grant is M1 again; both requesters then alternate M0,M1,M0,M1.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin
                bus.m0_req_i = 1; bus.m0_addr_i = 32'h200; bus.m0_be_i = 4'h1;
                bus.m1_req_i = 1; bus.m1_addr_i = 32'h300; bus.m1_be_i = 4'h2; bus.m1_we_i = 1;
                bus.mem_gnt_i = 1;
            end
            if (k > 0) begin
                bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hA000_0000 + 32'(k);
            end
            settle();
            if (k < 4) begin
                check($sformatf("t2_m0_gnt_%0d", k), {31'b0, bus.m0_gnt_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("t2_m1_gnt_%0d", k), {31'b0, bus.m1_gnt_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
                check($sformatf("t2_addr_%0d", k), bus.mem_addr_o, (k % 2 == 0) ? 32'h200 : 32'h300);
            end
            if (k > 0) begin
                // Response k answers grant k-1: odd k -> M0, even k -> M1.
                check($sformatf("t2_m0_rv_%0d", k), {31'b0, bus.m0_rvalid_o}, (k % 2 == 1) ? 32'd1 : 32'd0);
                check($sformatf("t2_m1_rv_%0d", k), {31'b0, bus.m1_rvalid_o}, (k % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("t2_rdata_%0d", k), (k % 2 == 1) ? bus.m0_rdata_o : bus.m1_rdata_o,
                      32'hA000_0000 + 32'(k));
            end
            tick();
        end
        idle();

        // Outstanding limit: two grants, stall, third grant alongside the first response.
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h104; bus.mem_gnt_i = 1;
        settle();
        check("t3_gnt_c0", {31'b0, bus.m0_gnt_o}, 32'd1);
        tick();
        settle();
        check("t3_gnt_c1", {31'b0, bus.m0_gnt_o}, 32'd1);
        tick();
        settle();
        check("t3_gnt_full",     {31'b0, bus.m0_gnt_o}, 32'd0);
        check("t3_mem_req_full", {31'b0, bus.mem_req_o}, 32'd0);
        tick();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h11;
        settle();
        check("t3_gnt_pushpop", {31'b0, bus.m0_gnt_o}, 32'd1);
        check("t3_rv_pushpop",  {31'b0, bus.m0_rvalid_o}, 32'd1);
        check("t3_rd_pushpop",  bus.m0_rdata_o, 32'h11);
        tick();
        bus.m0_req_i = 0; bus.mem_gnt_i = 0; bus.mem_rdata_i = 32'h22;
        settle();
        check("t3_rd_2", bus.m0_rdata_o, 32'h22);
        tick();
        bus.mem_rdata_i = 32'h33;
        settle();
        check("t3_rd_3",  bus.m0_rdata_o, 32'h33);
        check("t3_err_3", {31'b0, bus.err_o}, 32'd0);
        tick();

        // FIFO now empty: a stray response raises err for one cycle only.
        bus.mem_rdata_i = 32'h44;
        settle();
        check("t5_err",       {31'b0, bus.err_o}, 32'd1);
        check("t5_m0_rvalid", {31'b0, bus.m0_rvalid_o}, 32'd0);
        check("t5_m1_rvalid", {31'b0, bus.m1_rvalid_o}, 32'd0);
        tick();
        idle();
        settle();
        check("t5_err_clear", {31'b0, bus.err_o}, 32'd0);
        tick();

        // Lone M1 grant leaves last_grant = M1, so plain arbitration would now favour M0.
        bus.m1_req_i = 1; bus.m1_addr_i = 32'h3F0; bus.mem_gnt_i = 1;
        settle();
        check("t4_pre_gnt", {31'b0, bus.m1_gnt_o}, 32'd1);
        tick();
        idle();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h3F;
        settle();
        check("t4_pre_rv", {31'b0, bus.m1_rvalid_o}, 32'd1);
        tick();
        idle();
        bus.m1_req_i = 1; bus.m1_addr_i = 32'h400; bus.m1_wdata_i = 32'hCAFE; bus.m1_we_i = 1;
        settle();
        check("t4_stall_c0_req", {31'b0, bus.mem_req_o}, 32'd1);
        check("t4_stall_c0_gnt", {31'b0, bus.m1_gnt_o}, 32'd0);
        tick();
        bus.m0_req_i = 1; bus.m0_addr_i = 32'h500;
        for (int c = 1; c < 3; c++) begin
            settle();
            check($sformatf("t4_lock_addr_%0d", c), bus.mem_addr_o, 32'h400);
            check($sformatf("t4_lock_we_%0d", c),   {31'b0, bus.mem_we_o}, 32'd1);
            check($sformatf("t4_lock_g0_%0d", c),   {31'b0, bus.m0_gnt_o}, 32'd0);
            tick();
        end
        bus.mem_gnt_i = 1;
        settle();
        check("t4_rel_m1_gnt", {31'b0, bus.m1_gnt_o}, 32'd1);
        check("t4_rel_m0_gnt", {31'b0, bus.m0_gnt_o}, 32'd0);
        check("t4_rel_wdata",  bus.mem_wdata_o, 32'hCAFE);
        tick();
        bus.m1_req_i = 0;
        settle();
        check("t4_m0_gnt",  {31'b0, bus.m0_gnt_o}, 32'd1);
        check("t4_m0_addr", bus.mem_addr_o, 32'h500);
        tick();
        idle();
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h55;
        settle();
        check("t4_rv_m1", {31'b0, bus.m1_rvalid_o}, 32'd1);
        tick();
        bus.mem_rdata_i = 32'h66;
        settle();
        check("t4_rv_m0", {31'b0, bus.m0_rvalid_o}, 32'd1);
        check("t4_rd_m0", bus.m0_rdata_o, 32'h66);
        tick();
        idle();

        // Two accesses outstanding, then reset: their late responses are flagged and dropped.
        bus.m0_req_i = 1; bus.m1_req_i = 1; bus.mem_gnt_i = 1;
        tick();
        tick();
        idle();
        rst_i = 1'b1;
        settle();
        check("t6_rst_mem_req", {31'b0, bus.mem_req_o}, 32'd0);
`ifdef ARB_PERF_CNT_EN
        check("t6_rst_m0_cnt", m0_gnt_cnt, 32'd0);
        check("t6_rst_m1_cnt", m1_gnt_cnt, 32'd0);
        check("t6_rst_stall",  stall_cnt,  32'd0);
`endif
        tick();
        rst_i = 1'b0;
        for (int r = 0; r < 2; r++) begin
            bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h77 + 32'(r);
            settle();
            check($sformatf("t6_err_%0d", r), {31'b0, bus.err_o}, 32'd1);
            check($sformatf("t6_rv_%0d", r),  {31'b0, bus.m0_rvalid_o | bus.m1_rvalid_o}, 32'd0);
            tick();
        end
        idle();
        bus.m0_req_i = 1; bus.m1_req_i = 1; bus.mem_gnt_i = 1;
        settle();
        check("t6_err_clear",  {31'b0, bus.err_o}, 32'd0);
        check("t6_tie_m0_gnt", {31'b0, bus.m0_gnt_o}, 32'd1);
        check("t6_tie_m1_gnt", {31'b0, bus.m1_gnt_o}, 32'd0);
        tick();
        idle();
`ifdef ARB_PERF_CNT_EN
        settle();
        check("t6_m0_cnt_one", m0_gnt_cnt, 32'd1);
        check("t6_m1_cnt_zero", m1_gnt_cnt, 32'd0);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one data-memory port between two requesters: M0 (instruction fetch) and M1 (load/store unit).
- Round-robin grant with a valid/gnt request handshake; read responses are decoupled from grants (rvalid).
- An in-order ID FIFO records which requester owns each outstanding access and routes each response back to it.
- Sits between the core's fetch/LSU ports and the memory model.

Parameters:
- XLEN, riscv_pkg::XLEN (32): address/data width.
- MAX_OUTSTANDING, 2: depth of the ID FIFO, i.e. maximum accepted-but-unanswered accesses (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- mN_req_i  in  1  request valid (N = 0, 1; same set per requester)
- mN_we_i  in  1  1 = write, 0 = read
- mN_addr_i  in  XLEN  byte address
- mN_wdata_i  in  XLEN  write data
- mN_be_i  in  4  byte enables
- mN_gnt_o  out  1  request accepted this cycle
- mN_rvalid_o  out  1  response valid
- mN_rdata_o  out  XLEN  read data
- mem_req_o  out  1  request to memory
- mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o  out  1/XLEN/XLEN/4  muxed request fields
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid (reads and writes both respond)
- mem_rdata_i  in  XLEN  memory read data
- err_o  out  1  one-cycle pulse on an unexpected response

Behaviour:
- Reset values: all gnt/rvalid/req/err outputs 0; FIFO empty; last_grant = M1, so M0 wins the first tie.
- Arbitration (combinational):
  - Only one requester active: it is selected.
  - Both active: the requester other than last_grant is selected.
  - last_grant updates only on an accepted request.
- Memory request:
  - mem_req_o = selected req AND can_issue.
  - can_issue = (count < MAX_OUTSTANDING) OR mem_rvalid_i, so push and pop are allowed in the same cycle when the FIFO is full.
  - mem_* fields are muxed from the selected requester. When idle they hold the M0 fields, which are don't-care.
- Grant:
  - mN_gnt_o = mem_req_o AND mem_gnt_i AND (selected == N). This is combinational; no registered latency is added on the request path.
  - A requester must hold req and its fields stable until gnt. The arbiter does not switch selection while a request is stalled by mem_gnt_i = 0, even if the other requester raises req (lock register).
- ID FIFO:
  - Push the selected ID on every accepted grant.
  - Pop on mem_rvalid_i.
  - count width: $clog2(MAX_OUTSTANDING+1). Pointers wrap modulo MAX_OUTSTANDING.
- Response routing:
  - On mem_rvalid_i with the FIFO non-empty: m[head]_rvalid_o = 1 and m[head]_rdata_o = mem_rdata_i in the same cycle. The other requester's rvalid stays 0.
  - rdata outputs are 0 when their rvalid is 0.
- Unexpected response: mem_rvalid_i with the FIFO empty → no rvalid to any requester, err_o = 1 for that cycle, state unchanged.
- Ordering: responses are assumed to arrive in grant order (in-order memory).
- Reset mid-operation:
  - FIFO is cleared; outstanding accesses are forgotten.
  - Their late responses trigger err_o and are dropped.

Optional Feature:
- ARB_PERF_CNT_EN defined adds:
  - outputs m0_gnt_cnt_o and m1_gnt_cnt_o (32 bits): count accepted grants per requester, wrap at 2^32, reset to 0.
  - stall_cnt_o (32 bits): counts cycles where some req is high but no grant occurs.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- riscv_pkg additions:
  - typedef mem_req_t (we, addr, wdata, be).
  - typedef enum requester_id_e {REQ_IFETCH, REQ_LSU}.
  - constant MEM_BE_W = 4.
- Sub-module arb_id_fifo: parameterised depth, push/pop/full/empty/count, and simultaneous push+pop when full.

Test Plan:
- Lone M0 read of addr 0x100, mem_gnt_i = 1, memory returns 0xDEADBEEF next cycle → m0_gnt_o = 1 in cycle 0; m0_rvalid_o = 1 with rdata 0xDEADBEEF in cycle 1; M1 signals stay 0.
- Both requesting continuously for 4 grants → grant order M0, M1, M0, M1; each response is routed to its owner.
- MAX_OUTSTANDING = 2, responses withheld → two grants, then gnt stays 0. A third grant is issued in the same cycle the first mem_rvalid_i arrives.
- mem_gnt_i = 0 for 3 cycles while M1 is stalled and M0 raises req → M1 stays selected (fields unchanged) and is granted when mem_gnt_i rises.
- mem_rvalid_i with the FIFO empty → err_o pulses for one cycle; no mN_rvalid_o.
- Assert rst_i with 2 outstanding, then deliver 2 responses → err_o pulses twice. With ARB_PERF_CNT_EN, the grant counters read 0 after reset.
